// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_arbiter
//  Purpose  : Shares one byte-level I2C master engine between REQ_NUM local
//             requesters. Each requester posts a single-byte transaction
//             (address, direction, write data). Requests are granted
//             round-robin and the engine is sequenced through
//             START -> address byte -> data byte -> STOP. Read data and NACK
//             status are returned to the granted requester with done_o.
//  Ports    : clk_i, a_rst_i         clock, asynchronous active-high reset
//             req_i/addr_i/rw_i/wdata_i  requester side (packed per requester)
//             gnt_o/done_o/rdata_o/nack_o  grant, completion, results
//             bus_busy_i             external master currently owns the bus
//             cmd_*                  command channel to the engine
//             resp_*                 response channel from the engine
//  Revision : 1.0  initial release
// ============================================================================
module i2c_master_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk_i,
    input  logic                              a_rst_i,
    input  logic [REQ_NUM-1:0]                req_i,
    input  logic [REQ_NUM*(DATA_WIDTH-1)-1:0] addr_i,
    input  logic [REQ_NUM-1:0]                rw_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]     wdata_i,
    output logic [REQ_NUM-1:0]                gnt_o,
    output logic [REQ_NUM-1:0]                done_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              nack_o,
    input  logic                              bus_busy_i,
    output logic                              cmd_valid_o,
    input  logic                              cmd_ready_i,
    output logic [1:0]                        cmd_o,
    output logic [DATA_WIDTH-1:0]             cmd_data_o,
    input  logic                              resp_valid_i,
    input  logic [DATA_WIDTH-1:0]             resp_data_i,
    input  logic                              resp_nack_i
);

    localparam int ADDR_WIDTH = DATA_WIDTH - 1;
    localparam int c_PW       = $clog2(REQ_NUM);
    localparam int c_IW       = c_PW + 1;   // holds rr_ptr + offset before wrap

    localparam logic [1:0] c_CMD_START = 2'd0;
    localparam logic [1:0] c_CMD_WRITE = 2'd1;
    localparam logic [1:0] c_CMD_READ  = 2'd2;
    localparam logic [1:0] c_CMD_STOP  = 2'd3;

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_ARB        = 4'd1;
    localparam logic [3:0] c_ST_START      = 4'd2;
    localparam logic [3:0] c_ST_WAIT_START = 4'd3;
    localparam logic [3:0] c_ST_ADDR       = 4'd4;
    localparam logic [3:0] c_ST_WAIT_ADDR  = 4'd5;
    localparam logic [3:0] c_ST_DATA       = 4'd6;
    localparam logic [3:0] c_ST_WAIT_DATA  = 4'd7;
    localparam logic [3:0] c_ST_STOP       = 4'd8;
    localparam logic [3:0] c_ST_WAIT_STOP  = 4'd9;
    localparam logic [3:0] c_ST_DONE       = 4'd10;

    localparam logic [REQ_NUM-1:0] c_GNT_ONE = {{(REQ_NUM-1){1'b0}}, 1'b1};

    logic [3:0]            r_state;
    logic [c_PW-1:0]       r_rr_ptr;
    logic [REQ_NUM-1:0]    r_gnt;
    logic [REQ_NUM-1:0]    r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rw;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_lat;
    logic                  r_nack_flag;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_nack;
    logic                  r_cmd_valid;
    logic [1:0]            r_cmd;
    logic [DATA_WIDTH-1:0] r_cmd_data;

    logic                  w_found;
    logic [c_PW-1:0]       w_winner;
    logic [c_IW-1:0]       w_idx;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_rw;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_accept;

    assign w_accept = r_cmd_valid & cmd_ready_i;

    // Round-robin search: first set request starting just after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            w_idx = {1'b0, r_rr_ptr} + c_IW'(i);
            if (w_idx >= c_IW'(REQ_NUM)) begin
                w_idx = w_idx - c_IW'(REQ_NUM);
            end
            if (!w_found && req_i[w_idx[c_PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_PW-1:0];
            end
        end
    end

    // Winner's transaction fields, selected with constant slices.
    always_comb begin
        w_addr  = '0;
        w_rw    = 1'b0;
        w_wdata = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (w_winner == c_PW'(k)) begin
                w_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_rw    = rw_i[k];
                w_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= c_PW'(REQ_NUM - 1);
            r_gnt       <= '0;
            r_done      <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_wdata     <= '0;
            r_rdata_lat <= '0;
            r_nack_flag <= 1'b0;
            r_rdata     <= '0;
            r_nack      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= c_CMD_START;
            r_cmd_data  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // An external master only blocks starting a new transaction.
                    if (|req_i && !bus_busy_i) begin
                        r_state <= c_ST_ARB;
                    end
                end
                c_ST_ARB: begin
                    if (w_found) begin
                        r_gnt       <= c_GNT_ONE << w_winner;
                        r_rr_ptr    <= w_winner;
                        r_addr      <= w_addr;
                        r_rw        <= w_rw;
                        r_wdata     <= w_wdata;
                        r_nack_flag <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= c_CMD_START;
                        r_cmd_data  <= '0;
                        r_state     <= c_ST_START;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_START: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_START;
                    end
                end
                c_ST_WAIT_START: begin
                    if (resp_valid_i) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= c_CMD_WRITE;
                        r_cmd_data  <= {r_addr, r_rw};
                        r_state     <= c_ST_ADDR;
                    end
                end
                c_ST_ADDR: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_ADDR;
                    end
                end
                c_ST_WAIT_ADDR: begin
                    if (resp_valid_i) begin
                        r_cmd_valid <= 1'b1;
                        if (resp_nack_i) begin
                            // Nobody answered the address: skip data, release the bus.
                            r_nack_flag <= 1'b1;
                            r_cmd       <= c_CMD_STOP;
                            r_cmd_data  <= '0;
                            r_state     <= c_ST_STOP;
                        end else begin
                            r_cmd      <= r_rw ? c_CMD_READ : c_CMD_WRITE;
                            r_cmd_data <= r_rw ? '0 : r_wdata;
                            r_state    <= c_ST_DATA;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_DATA;
                    end
                end
                c_ST_WAIT_DATA: begin
                    if (resp_valid_i) begin
                        if (r_rw) begin
                            r_rdata_lat <= resp_data_i;
                        end else begin
                            r_nack_flag <= resp_nack_i;
                        end
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= c_CMD_STOP;
                        r_cmd_data  <= '0;
                        r_state     <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_ST_WAIT_STOP;
                    end
                end
                c_ST_WAIT_STOP: begin
                    if (resp_valid_i) begin
                        r_done  <= r_gnt;
                        r_rdata <= r_rdata_lat;
                        r_nack  <= r_nack_flag;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_gnt       <= '0;
                    r_done      <= '0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign done_o      = r_done;
    assign rdata_o     = r_rdata;
    assign nack_o      = r_nack;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_o       = r_cmd;
    assign cmd_data_o  = r_cmd_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_arbiter
//  Purpose  : Directed self-checking bench for i2c_master_arbiter with a
//             behavioural byte engine that answers each accepted command
//             one cycle later and records the command stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_master_arbiter;

    localparam int REQ_NUM = 4;
    localparam int DW      = 8;
    localparam int AW      = DW - 1;

    logic                 clk_i = 1'b0;
    logic                 a_rst_i;
    logic [REQ_NUM-1:0]   req_i;
    logic [REQ_NUM*AW-1:0] addr_i;
    logic [REQ_NUM-1:0]   rw_i;
    logic [REQ_NUM*DW-1:0] wdata_i;
    logic [REQ_NUM-1:0]   gnt_o;
    logic [REQ_NUM-1:0]   done_o;
    logic [DW-1:0]        rdata_o;
    logic                 nack_o;
    logic                 bus_busy_i;
    logic                 cmd_valid_o;
    logic                 cmd_ready_i;
    logic [1:0]           cmd_o;
    logic [DW-1:0]        cmd_data_o;
    logic                 resp_valid_i;
    logic [DW-1:0]        resp_data_i;
    logic                 resp_nack_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine model state and command log.
    logic       nack_addr;
    logic       nack_data;
    logic       e_acc;
    logic [1:0] e_cmd;
    logic [7:0] e_data;
    int         e_wr;
    int         log_n = 0;
    logic [1:0] log_cmd  [0:255];
    logic [7:0] log_data [0:255];

    i2c_master_arbiter #(.REQ_NUM(REQ_NUM), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .a_rst_i      (a_rst_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .rw_i         (rw_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .nack_o       (nack_o),
        .bus_busy_i   (bus_busy_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_o        (cmd_o),
        .cmd_data_o   (cmd_data_o),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .resp_nack_i  (resp_nack_i)
    );

    always #5 clk_i = ~clk_i;

    // Engine: a command accepted at an edge is answered during the next cycle.
    initial begin
        resp_valid_i = 1'b0;
        resp_nack_i  = 1'b0;
        e_wr         = 0;
        forever begin
            @(posedge clk_i);
            e_acc  = cmd_valid_o && cmd_ready_i;
            e_cmd  = cmd_o;
            e_data = cmd_data_o;
            #1;
            resp_valid_i = 1'b0;
            resp_nack_i  = 1'b0;
            if (e_acc && !a_rst_i) begin
                log_cmd[log_n]  = e_cmd;
                log_data[log_n] = e_data;
                log_n           = log_n + 1;
                resp_valid_i    = 1'b1;
                if (e_cmd == 2'd0) begin
                    e_wr = 0;
                end else if (e_cmd == 2'd1) begin
                    resp_nack_i = (e_wr == 0) ? nack_addr : nack_data;
                    e_wr        = e_wr + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Waits for a done pulse; cyc is the number of edges after the request cycle.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc = cyc + 1;
            if (done_o != '0) break;
        end
    endtask

    int cyc;
    int base;
    int stable;

    initial begin
        a_rst_i     = 1'b1;
        req_i       = '0;
        addr_i      = '0;
        rw_i        = '0;
        wdata_i     = '0;
        bus_busy_i  = 1'b0;
        cmd_ready_i = 1'b1;
        resp_data_i = '0;
        nack_addr   = 1'b0;
        nack_data   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_gnt",  {28'd0, gnt_o}, 32'h0);
        check("rst_done", {28'd0, done_o}, 32'h0);
        check("rst_cmd",  {21'd0, cmd_valid_o, cmd_o, cmd_data_o}, 32'h0);
        check("rst_res",  {23'd0, nack_o, rdata_o}, 32'h0);
        a_rst_i = 1'b0;
        tick();

        // Single write from requester 0
        base = log_n;
        addr_i[0*AW +: AW]  = 7'h50;
        wdata_i[0*DW +: DW] = 8'hA5;
        rw_i[0]             = 1'b0;
        req_i               = 4'b0001;
        wait_done(cyc);
        check("wr_latency", cyc + 1, 11);
        check("wr_done",    {28'd0, done_o}, 32'h1);
        check("wr_ncmd",    log_n - base, 4);
        check("wr_seq",     {log_cmd[base], log_cmd[base+1], log_data[base+1],
                             log_cmd[base+2], log_data[base+2], log_cmd[base+3]},
                            {2'd0, 2'd1, 8'hA0, 2'd1, 8'hA5, 2'd3});
        check("wr_nack",    {31'd0, nack_o}, 32'h0);
        req_i = '0;
        tick();
        check("wr_gnt_clr", {28'd0, gnt_o, done_o}, 32'h0);

        // Single read from requester 2
        base = log_n;
        addr_i[2*AW +: AW] = 7'h3C;
        rw_i[2]            = 1'b1;
        resp_data_i        = 8'h5A;
        req_i              = 4'b0100;
        wait_done(cyc);
        check("rd_done",  {28'd0, done_o}, 32'h4);
        check("rd_addr",  {24'd0, log_data[base+1]}, 32'h79);
        check("rd_cmd",   {30'd0, log_cmd[base+2]}, 32'h2);
        check("rd_rdata", {24'd0, rdata_o}, 32'h5A);
        check("rd_nack",  {31'd0, nack_o}, 32'h0);
        req_i = '0;
        tick();

        // Address NACK on a write from requester 3
        base = log_n;
        nack_addr           = 1'b1;
        addr_i[3*AW +: AW]  = 7'h11;
        wdata_i[3*DW +: DW] = 8'h33;
        rw_i[3]             = 1'b0;
        req_i               = 4'b1000;
        wait_done(cyc);
        check("an_done",  {28'd0, done_o}, 32'h8);
        check("an_ncmd",  log_n - base, 3);
        check("an_seq",   {log_cmd[base+1], log_data[base+1], log_cmd[base+2]},
                          {2'd1, 8'h22, 2'd3});
        check("an_nack",  {31'd0, nack_o}, 32'h1);
        check("an_rdata", {24'd0, rdata_o}, 32'h5A);
        nack_addr = 1'b0;
        req_i     = '0;
        tick();

        // Round-robin with all requesters held
        rw_i  = '0;
        req_i = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [3:0] exp_g;
            exp_g = (t == 0 || t == 4) ? 4'b0001 :
                    (t == 1) ? 4'b0010 : (t == 2) ? 4'b0100 : 4'b1000;
            wait_done(cyc);
            if (t == 4) req_i = '0;
            check($sformatf("rr_grant%0d", t), {28'd0, done_o}, {28'd0, exp_g});
        end
        tick();

        // Bus busy blocks new arbitration
        bus_busy_i = 1'b1;
        req_i      = 4'b0001;
        for (int t = 0; t < 6; t++) tick();
        check("busy_nogrant", {28'd0, gnt_o}, 32'h0);
        bus_busy_i = 1'b0;
        tick();
        tick();
        check("busy_grant", {28'd0, gnt_o}, 32'h1);
        wait_done(cyc);
        check("busy_done", {28'd0, done_o}, 32'h1);
        req_i = '0;
        tick();

        // Command stall with data NACK on write from requester 1
        cmd_ready_i         = 1'b0;
        nack_data           = 1'b1;
        wdata_i[1*DW +: DW] = 8'hC3;
        addr_i[1*AW +: AW]  = 7'h2A;
        req_i               = 4'b0010;
        tick();
        tick();
        check("stall_valid", {30'd0, cmd_valid_o, gnt_o[1]}, 32'h3);
        stable = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (cmd_valid_o && cmd_o == 2'd0 && cmd_data_o == 8'h00) stable = stable + 1;
        end
        check("stall_hold", stable, 5);
        cmd_ready_i = 1'b1;
        wait_done(cyc);
        check("stall_done",  {28'd0, done_o}, 32'h2);
        check("dn_nack",     {31'd0, nack_o}, 32'h1);
        check("dn_rdata",    {24'd0, rdata_o}, 32'h5A);
        nack_data = 1'b0;
        req_i     = '0;
        tick();

        // Asynchronous reset while the data command is pending
        base = log_n;
        wdata_i[0*DW +: DW] = 8'h77;
        req_i               = 4'b0001;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (log_n - base >= 2) break;
        end
        cmd_ready_i = 1'b0;
        tick();
        check("mid_data", {21'd0, cmd_valid_o, cmd_o, cmd_data_o}, {21'd0, 1'b1, 2'd1, 8'h77});
        #2;
        a_rst_i = 1'b1;
        #1;
        check("arst_clear", {26'd0, gnt_o, done_o[0], cmd_valid_o}, 32'h0);
        tick();
        a_rst_i     = 1'b0;
        cmd_ready_i = 1'b1;
        tick();
        check("arst_idle_arb", {28'd0, gnt_o}, 32'h0);
        tick();
        check("arst_regrant",  {28'd0, gnt_o}, 32'h1);
        wait_done(cyc);
        check("arst_done", {28'd0, done_o}, 32'h1);
        req_i = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one byte-level I2C master engine between REQ_NUM local requesters.
- Each requester posts a single-byte transaction: target address, direction, and write data.
- The block arbitrates round-robin and sequences the engine through START, address byte, data byte and STOP.
- It returns read data and a NACK status to the granted requester. It sits between system-side clients and the I2C master engine / pad logic.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- DATA_WIDTH, 8, I2C byte width.
- ADDR_WIDTH, 7, target address width (DATA_WIDTH - 1, localparam).

Ports:
- clk_i  in  1  system clock.
- a_rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  REQ_NUM  per-requester transaction request; level, held until done_o.
- addr_i  in  REQ_NUM*ADDR_WIDTH  packed target addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- rw_i  in  REQ_NUM  direction per requester; 1 = read, 0 = write.
- wdata_i  in  REQ_NUM*DATA_WIDTH  packed write data.
- gnt_o  out  REQ_NUM  one-hot grant, held for the whole transaction.
- done_o  out  REQ_NUM  one-cycle completion pulse to the granted requester.
- rdata_o  out  DATA_WIDTH  read data, valid with done_o.
- nack_o  out  1  NACK status, valid with done_o.
- bus_busy_i  in  1  external master owns the bus (START seen, STOP not yet seen).
- cmd_valid_o  out  1  command valid to the engine.
- cmd_ready_i  in  1  engine accepts the command.
- cmd_o  out  2  command code: 0 START, 1 WRITE, 2 READ, 3 STOP.
- cmd_data_o  out  DATA_WIDTH  byte for WRITE.
- resp_valid_i  in  1  engine completed the oldest command; exactly one pulse per command.
- resp_data_i  in  DATA_WIDTH  byte received on READ.
- resp_nack_i  in  1  ACK bit sampled on WRITE (1 = NACK).

Behaviour:
- Reset (asynchronous): FSM = IDLE; rr_ptr = REQ_NUM-1; gnt_o, done_o, cmd_valid_o, nack_o = 0; rdata_o, cmd_o, cmd_data_o = 0.
- Command handshake:
  - cmd_valid_o rises and cmd_o/cmd_data_o are stable until the cycle with cmd_valid_o & cmd_ready_i.
  - cmd_valid_o drops the cycle after acceptance.
  - Only one command is outstanding; a resp_valid_i arriving while none is outstanding is ignored.
- FSM states: IDLE, ARB, START, ADDR, WAIT_ADDR, DATA, WAIT_DATA, STOP, WAIT_STOP, DONE.
- IDLE:
  - If |req_i and !bus_busy_i, go to ARB.
  - bus_busy_i blocks only new arbitration, never an in-flight transaction.
- ARB:
  - Pick the first set req_i bit searching from rr_ptr+1 modulo REQ_NUM. Set the one-hot gnt_o and rr_ptr = winner.
  - Latch addr, rw and wdata of the winner into internal registers; later changes on the inputs are ignored.
  - Go to START.
  - If req_i is now all zero, return to IDLE with no grant.
- START: issue cmd 0; on accept, go to WAIT state, then to ADDR on resp_valid_i.
- ADDR: issue WRITE with cmd_data_o = {addr, rw}; on accept, go to WAIT_ADDR.
- WAIT_ADDR: on resp_valid_i, if resp_nack_i then set nack_flag=1 and go to STOP (data phase skipped), else go to DATA.
- DATA:
  - rw=0: issue WRITE with wdata.
  - rw=1: issue READ.
  - On accept, go to WAIT_DATA.
- WAIT_DATA: on resp_valid_i, capture resp_data_i into rdata (read), or capture resp_nack_i into nack_flag (write). Go to STOP.
- STOP: issue cmd 3; on resp_valid_i go to DONE.
- DONE:
  - One cycle: done_o[winner]=1, rdata_o and nack_o driven from the latched values.
  - gnt_o clears on the next cycle; go to IDLE.
- Latency, no stalls (cmd_ready_i=1, resp_valid_i the cycle after accept): request to done_o = 1 (IDLE→ARB) + 1 + 4 commands × 2 cycles + 1 = 11 cycles.
- Requester drops req_i while granted: the transaction still completes (STOP is always issued) and done_o still pulses.
- Simultaneous requests: round-robin guarantees service within REQ_NUM transactions, with no starvation.
- rdata_o and nack_o hold their last values until the next DONE.
- A write with data NACK reports nack_o=1; rdata_o is left unchanged on writes.
- Reset mid-transaction returns to IDLE immediately with cmd_valid_o=0. Engine recovery is outside this block's scope.

Test Plan:
- Single write: req_i=0001, addr0=0x50, rw=0, wdata=0xA5, engine ACKs. Expected: cmd_data_o sequence 0xA0 then 0xA5; done_o=0001 at cycle 11; nack_o=0.
- Single read: req_i=0100, addr2=0x3C, rw=1, resp_data_i=0x5A. Expected: cmd_data_o 0x79, then a READ command; rdata_o=0x5A with done_o=0100.
- Address NACK: resp_nack_i=1 on the address byte. Expected: no DATA command, STOP issued next, nack_o=1.
- Round-robin: req_i=1111 held for 4 transactions. Expected: grant order 0001, 0010, 0100, 1000, then 0001 again.
- Stalls and bus busy:
  - bus_busy_i=1 with req_i=0001: expected no grant until bus_busy_i=0.
  - cmd_ready_i low for 5 cycles: expected cmd_valid_o/cmd_o held stable.
- Reset mid-DATA: assert a_rst_i asynchronously. Expected: gnt_o=0 and cmd_valid_o=0 before the next clock edge; FSM in IDLE.
